// File: rtl/toggle_period_meter.sv
// toggle_period_meter
//
// Measures the interval between successive edges (rising or falling) of an
// asynchronous square wave, in sys_clk cycles. It reports each completed
// interval with a one-cycle strobe, tracks whether the recent intervals sit
// inside a tolerance window around the expected half-period, and flags a
// stalled input.
//
// Ports
//   sys_clk       in   system clock
//   sys_rst_n     in   asynchronous active-low reset
//   sig_in        in   asynchronous square wave under test
//   half_period   out  [25:0] last completed interval, in sys_clk cycles
//   period_valid  out  one-cycle strobe: half_period was updated this cycle
//   locked        out  LOCK_N consecutive intervals inside CNT_MAX+1 +/- TOL
//   timeout       out  no edge seen for TIMEOUT_MAX cycles
//   dbg_state_o   out  [1:0] FSM state (0 WAIT_EDGE, 1 MEASURE, 2 TIMED_OUT)
//
// There is no handshake: period_valid is a pure strobe with no ready/back-
// pressure, and half_period holds its value until the next strobe.

module toggle_period_meter #(
  parameter logic [24:0] CNT_MAX     = 25'd24_999_999,
  parameter logic [24:0] TOL         = 25'd1000,
  parameter logic [25:0] TIMEOUT_MAX = 26'd50_000_000,
  parameter logic [2:0]  LOCK_N      = 3'd4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        sig_in,
  output logic [25:0] half_period,
  output logic        period_valid,
  output logic        locked,
  output logic        timeout,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    MEASURE   = 2'd1,
    TIMED_OUT = 2'd2
  } state_t;

  // Tolerance window, computed in 26 bits so CNT_MAX+1+TOL cannot wrap for
  // any 25-bit parameter values. The lower bound clamps at 0 instead of
  // wrapping when TOL exceeds the target.
  localparam logic [25:0] TARGET   = {1'b0, CNT_MAX} + 26'd1;
  localparam logic [25:0] TOL_W    = {1'b0, TOL};
  localparam logic [25:0] LO_BOUND = (TARGET > TOL_W) ? (TARGET - TOL_W) : 26'd0;
  localparam logic [25:0] HI_BOUND = TARGET + TOL_W;

  // Synchronizer (s1, s2) plus one delay stage (sd) for edge detection.
  logic s1_q;
  logic s2_q;
  logic sd_q;

  state_t      state_q;
  logic [25:0] cnt_q;
  logic [25:0] half_period_q;
  logic        period_valid_q;
  logic        locked_q;
  logic        timeout_q;
  logic [2:0]  match_cnt_q;
  logic [2:0]  match_cnt_d;

  logic edge_det;
  logic in_tol;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      sd_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      sd_q <= s2_q;
    end
  end

  // Either polarity of transition is an edge; with sd reset to 0, a high
  // sig_in at reset release shows up as the first edge.
  assign edge_det = s2_q ^ sd_q;

  // cnt_q holds the number of cycles since the previous edge-detect cycle
  // at the moment the current edge is detected.
  assign in_tol = (cnt_q >= LO_BOUND) && (cnt_q <= HI_BOUND);

  // Saturating successor of the consecutive-match count.
  always_comb begin
    match_cnt_d = match_cnt_q;
    if (match_cnt_q < LOCK_N) begin
      match_cnt_d = match_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q        <= WAIT_EDGE;
      cnt_q          <= 26'd0;
      half_period_q  <= 26'd0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      timeout_q      <= 1'b0;
      match_cnt_q    <= 3'd0;
    end else begin
      period_valid_q <= 1'b0;
      case (state_q)
        // First edge after reset only opens a measurement window.
        WAIT_EDGE: begin
          cnt_q <= 26'd0;
          if (edge_det) begin
            state_q <= MEASURE;
            cnt_q   <= 26'd1;
          end
        end

        // An edge takes priority over the timeout check, so an interval of
        // exactly TIMEOUT_MAX is still reported as a measurement.
        MEASURE: begin
          if (edge_det) begin
            half_period_q  <= cnt_q;
            period_valid_q <= 1'b1;
            cnt_q          <= 26'd1;
            if (in_tol) begin
              match_cnt_q <= match_cnt_d;
              locked_q    <= (match_cnt_d == LOCK_N);
            end else begin
              match_cnt_q <= 3'd0;
              locked_q    <= 1'b0;
            end
          end else if (cnt_q == TIMEOUT_MAX) begin
            state_q     <= TIMED_OUT;
            timeout_q   <= 1'b1;
            locked_q    <= 1'b0;
            match_cnt_q <= 3'd0;
            cnt_q       <= 26'd0;
          end else begin
            cnt_q <= cnt_q + 26'd1;
          end
        end

        // The interval spanning the stall is unknown, so the recovering
        // edge restarts measurement without a strobe.
        TIMED_OUT: begin
          if (edge_det) begin
            state_q   <= MEASURE;
            timeout_q <= 1'b0;
            cnt_q     <= 26'd1;
          end
        end

        default: begin
          state_q <= WAIT_EDGE;
          cnt_q   <= 26'd0;
        end
      endcase
    end
  end

  assign half_period  = half_period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_toggle_period_meter.sv
// Testbench for toggle_period_meter (CNT_MAX=9, TOL=1, TIMEOUT_MAX=40,
// LOCK_N=4). A timestamp-based reference model checks every cycle; tables
// of intervals check the strobe contents for the key scenarios.

module tb_toggle_period_meter;

  localparam int P_CNT_MAX = 9;
  localparam int P_TOL     = 1;
  localparam int P_TMO     = 40;
  localparam int P_LOCK    = 4;

  // ---------------- clock / reset ----------------
  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        sig_in;
  logic [25:0] half_period;
  logic        period_valid;
  logic        locked;
  logic        timeout;
  logic [1:0]  dbg_state_o;

  always #5 sys_clk = ~sys_clk;

  toggle_period_meter #(
    .CNT_MAX     (25'd9),
    .TOL         (25'd1),
    .TIMEOUT_MAX (26'd40),
    .LOCK_N      (3'd4)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .sig_in       (sig_in),
    .half_period  (half_period),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Mode: 0 waiting for first edge, 1 measuring, 2 timed out.
  // Edges are tracked as the cycle numbers at which they take effect.
  int          cyc = 0;
  int          act_q[$];
  logic        last_sampled;
  int          m_mode;
  int          m_last;
  int          m_run;
  logic [25:0] m_half;
  logic        m_valid;
  logic        m_locked;
  logic        m_timeout;

  task automatic model_reset();
    act_q.delete();
    last_sampled = 1'b0;
    m_mode    = 0;
    m_last    = 0;
    m_run     = 0;
    m_half    = 26'd0;
    m_valid   = 1'b0;
    m_locked  = 1'b0;
    m_timeout = 1'b0;
  endtask

  // Drive sig_in for the next clock, advance one cycle, update the model
  // and compare every output.
  task automatic step(input logic v);
    int interval;
    int diff;
    bit edge_now;
    sig_in = v;
    // A change sampled on the next edge takes effect two edges later.
    if (v !== last_sampled) begin
      act_q.push_back(cyc + 3);
      last_sampled = v;
    end
    @(posedge sys_clk);
    cyc++;
    edge_now = 1'b0;
    if (act_q.size() > 0 && act_q[0] == cyc) begin
      void'(act_q.pop_front());
      edge_now = 1'b1;
    end
    m_valid = 1'b0;
    if (edge_now) begin
      if (m_mode == 1) begin
        interval = cyc - m_last;
        m_half   = 26'(interval);
        m_valid  = 1'b1;
        diff     = interval - (P_CNT_MAX + 1);
        if (diff < 0) diff = -diff;
        if (diff <= P_TOL) begin
          m_run = (m_run < P_LOCK) ? m_run + 1 : P_LOCK;
        end else begin
          m_run = 0;
        end
        m_locked = (m_run == P_LOCK);
      end
      m_timeout = 1'b0;
      m_mode    = 1;
      m_last    = cyc;
    end else if (m_mode == 1 && (cyc - m_last) == P_TMO) begin
      m_mode    = 2;
      m_timeout = 1'b1;
      m_locked  = 1'b0;
      m_run     = 0;
    end
    #1;
    check("half_period", half_period, m_half);
    check("period_valid", 26'(period_valid), 26'(m_valid));
    check("locked", 26'(locked), 26'(m_locked));
    check("timeout", 26'(timeout), 26'(m_timeout));
    check("state", 26'(dbg_state_o), 26'(m_mode));
  endtask

  // Assert reset between clock edges, check the asynchronous clear, then
  // release a few cycles later with sig_in held at hold_val.
  task automatic do_reset(input logic hold_val);
    sys_rst_n = 1'b0;
    sig_in    = hold_val;
    #1;
    check("rst_half_period", half_period, 26'd0);
    check("rst_period_valid", 26'(period_valid), 26'd0);
    check("rst_locked", 26'(locked), 26'd0);
    check("rst_timeout", 26'(timeout), 26'd0);
    check("rst_state", 26'(dbg_state_o), 26'd0);
    repeat (3) @(posedge sys_clk);
    #1;
    model_reset();
    sys_rst_n = 1'b1;
  endtask

  // ---------------- table-driven vectors ----------------
  // gap: cycles from the previous toggle (or from the start of the table)
  // to this toggle. The exp_* fields describe the output two cycles after
  // this toggle, when its edge takes effect.
  typedef struct {
    int          gap;
    logic        exp_valid;
    logic [25:0] exp_half;
    logic        exp_locked;
  } vec_t;

  vec_t tbl[$];
  logic cur;

  function automatic vec_t mk(input int g, input logic v, input int h, input logic l);
    vec_t r;
    r.gap        = g;
    r.exp_valid  = v;
    r.exp_half   = 26'(h);
    r.exp_locked = l;
    return r;
  endfunction

  task automatic check_pend(input vec_t p);
    check("tbl_period_valid", 26'(period_valid), 26'(p.exp_valid));
    check("tbl_half_period", half_period, p.exp_half);
    check("tbl_locked", 26'(locked), 26'(p.exp_locked));
  endtask

  // Every gap in a table is at least 2, so the previous toggle's edge lands
  // on the second cycle of the following vector. After the table, two more
  // cycles expose the last edge.
  task automatic run_table();
    bit   have_pend;
    vec_t pend;
    have_pend = 1'b0;
    foreach (tbl[i]) begin
      for (int j = 1; j <= tbl[i].gap; j++) begin
        step((j == tbl[i].gap) ? ~cur : cur);
        if (j == 2 && have_pend) begin
          check_pend(pend);
          have_pend = 1'b0;
        end
      end
      cur       = ~cur;
      pend      = tbl[i];
      have_pend = 1'b1;
    end
    if (have_pend) begin
      step(cur);
      step(cur);
      check_pend(pend);
    end
    tbl.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int g;
    sys_rst_n = 1'b1;
    sig_in    = 1'b0;
    cur       = 1'b0;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    do_reset(1'b0);
    cur = 1'b0;

    // Steady 10-cycle toggling, lock on 4th strobe, a 13 interval breaking
    // lock, re-lock, then tolerance boundaries 9/11 (match) and 8/12 (miss).
    tbl.push_back(mk(5, 1'b0, 0, 1'b0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(10, 1'b1, 10, 1'b0));
    tbl.push_back(mk(10, 1'b1, 10, 1'b1));
    tbl.push_back(mk(10, 1'b1, 10, 1'b1));
    tbl.push_back(mk(13, 1'b1, 13, 1'b0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(10, 1'b1, 10, 1'b0));
    tbl.push_back(mk(10, 1'b1, 10, 1'b1));
    tbl.push_back(mk(9,  1'b1, 9,  1'b1));
    tbl.push_back(mk(11, 1'b1, 11, 1'b1));
    tbl.push_back(mk(8,  1'b1, 8,  1'b0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(10, 1'b1, 10, 1'b0));
    tbl.push_back(mk(12, 1'b1, 12, 1'b0));
    tbl.push_back(mk(9,  1'b1, 9,  1'b0));
    tbl.push_back(mk(11, 1'b1, 11, 1'b0));
    tbl.push_back(mk(10, 1'b1, 10, 1'b0));
    tbl.push_back(mk(10, 1'b1, 10, 1'b1));
    run_table();

    // Stall: the last edge took effect on the previous cycle; timeout
    // must appear exactly 40 cycles after it, not one earlier.
    repeat (39) step(cur);
    check("pre_timeout", 26'(timeout), 26'd0);
    step(cur);
    check("timeout_set", 26'(timeout), 26'd1);
    check("timeout_unlock", 26'(locked), 26'd0);
    check("timeout_half_kept", half_period, 26'd10);

    // Recovery edge gives no strobe, then a normal 10, then an interval of
    // exactly TIMEOUT_MAX which must measure rather than time out.
    tbl.push_back(mk(5,  1'b0, 10, 1'b0));
    tbl.push_back(mk(10, 1'b1, 10, 1'b0));
    tbl.push_back(mk(40, 1'b1, 40, 1'b0));
    tbl.push_back(mk(10, 1'b1, 10, 1'b0));
    run_table();
    check("no_timeout_at_40", 26'(timeout), 26'd0);

    // Reach lock again (first gap adds the 2 flush cycles to make 10).
    tbl.push_back(mk(8,  1'b1, 10, 1'b0));
    tbl.push_back(mk(10, 1'b1, 10, 1'b0));
    tbl.push_back(mk(10, 1'b1, 10, 1'b1));
    run_table();
    repeat (3) step(cur);
    check("locked_before_reset", 26'(locked), 26'd1);

    // Reset mid-interval while locked; lock must be rebuilt from scratch.
    do_reset(1'b0);
    cur = 1'b0;
    tbl.push_back(mk(5, 1'b0, 0, 1'b0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(10, 1'b1, 10, 1'b0));
    tbl.push_back(mk(10, 1'b1, 10, 1'b1));
    run_table();

    // sig_in high at reset release: the synchronizer rise is the first edge,
    // so toggling 11 cycles later measures 10.
    do_reset(1'b1);
    cur = 1'b1;
    tbl.push_back(mk(11, 1'b1, 10, 1'b0));
    tbl.push_back(mk(10, 1'b1, 10, 1'b0));
    run_table();

    // Randomized intervals, including 1-cycle pulses and stalls past the
    // timeout, checked against the model every cycle.
    for (int k = 0; k < 120; k++) begin
      if (k == 60) begin
        do_reset(1'(($urandom_range(0, 1))));
        cur = sig_in;
      end
      if ($urandom_range(0, 3) == 0) g = $urandom_range(1, 45);
      else                           g = $urandom_range(8, 12);
      repeat (g - 1) step(cur);
      cur = ~cur;
      step(cur);
    end
    repeat (45) step(cur);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
